// File: rtl/bnn_pkg.sv
// Shared constants and width helpers for the BNN datapath.
// Consumers size their accumulators from acc_width() so DATA_WIDTH changes propagate.
package bnn_pkg;

    localparam int KERNEL_TAPS = 25;
    localparam int DOUT_WIDTH  = 32;
    localparam int TREE_LEVELS = 5;
    localparam int TREE_FANIN  = (KERNEL_TAPS + 1) / 2;

    // ceil(log2(KERNEL_TAPS*(2^dw-1))) + 2: magnitude bits plus sign and headroom.
    function automatic int acc_width(input int dw);
        longint mx;
        int     w;
        mx = longint'(KERNEL_TAPS) * ((longint'(1) << dw) - 1);
        w  = 0;
        while ((longint'(1) << w) < mx) w++;
        return w + 2;
    endfunction

    // Operand count at a given adder-tree level (level 0 = leaves).
    function automatic int level_cnt(input int lvl);
        int n;
        n = KERNEL_TAPS;
        for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
        return n;
    endfunction

endpackage

// File: rtl/bnn_signed_adder_tree.sv
// Combinational signed sum of 25 pixels, each added or subtracted by its weight bit.
// Pairwise reduction 25->13->7->4->2->1; odd leftovers pass through to the next level.
module bnn_signed_adder_tree
    import bnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SUM_W      = acc_width(DATA_WIDTH)
) (
    input  logic [KERNEL_TAPS-1:0][DATA_WIDTH-1:0] i_pix,
    input  logic [KERNEL_TAPS-1:0]                 i_weight,
    output logic signed [SUM_W-1:0]                o_sum
);

    logic signed [SUM_W-1:0] r_lvl [TREE_LEVELS+1][KERNEL_TAPS];

    always_comb begin
        r_lvl = '{default: '0};
        // Zero-extend before negating so pixels are always treated as unsigned.
        for (int i = 0; i < KERNEL_TAPS; i++) begin
            r_lvl[0][i] = i_weight[i] ? SUM_W'(i_pix[i]) : -SUM_W'(i_pix[i]);
        end
        for (int l = 1; l <= TREE_LEVELS; l++) begin
            for (int j = 0; j < TREE_FANIN; j++) begin
                if (j < level_cnt(l)) begin
                    if (2*j + 1 < level_cnt(l-1))
                        r_lvl[l][j] = r_lvl[l-1][2*j] + r_lvl[l-1][2*j+1];
                    else
                        r_lvl[l][j] = r_lvl[l-1][2*j];
                end
            end
        end
    end

    assign o_sum = r_lvl[TREE_LEVELS][0];

endmodule

// File: rtl/conv_5x5.sv
// Binary-weight 5x5 convolution: signed +/- pixel sum registered with one cycle latency.
// dout holds its last value while ivalid is low; only ovalid drops.
module conv_5x5
    import bnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              ivalid,
    input  logic [KERNEL_TAPS*DATA_WIDTH-1:0] idata,
    input  logic [KERNEL_TAPS-1:0]            weight,
    output logic                              ovalid,
    output logic signed [DOUT_WIDTH-1:0]      dout
);

    localparam int SUM_W = acc_width(DATA_WIDTH);

    logic [KERNEL_TAPS-1:0][DATA_WIDTH-1:0] w_pix;
    logic signed [SUM_W-1:0]                w_sum;
    logic signed [DOUT_WIDTH-1:0]           r_dout;
    logic                                   r_ovalid;

    assign w_pix = idata;

    bnn_signed_adder_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_W      (SUM_W)
    ) u_tree (
        .i_pix    (w_pix),
        .i_weight (weight),
        .o_sum    (w_sum)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout   <= '0;
            r_ovalid <= 1'b0;
        end else begin
            r_ovalid <= ivalid;
            if (ivalid)
                r_dout <= {{(DOUT_WIDTH-SUM_W){w_sum[SUM_W-1]}}, w_sum};
        end
    end

    assign dout   = r_dout;
    assign ovalid = r_ovalid;

endmodule

// File: tb/tb_conv_5x5.sv
// Directed checks of conv_5x5 with hand-computed results, plus a short random sweep
// against a straightforward per-pixel reference sum.
module tb_conv_5x5;

    localparam int DW = 8;
    localparam int NT = 25;

    logic                 clk;
    logic                 rstn;
    logic                 ivalid;
    logic [NT*DW-1:0]     idata;
    logic [NT-1:0]        weight;
    logic                 ovalid;
    logic signed [31:0]   dout;

    int n_vec = 0;
    int n_err = 0;

    conv_5x5 #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .ivalid (ivalid),
        .idata  (idata),
        .weight (weight),
        .ovalid (ovalid),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic logic [NT*DW-1:0] ramp();
        logic [NT*DW-1:0] d;
        for (int i = 0; i < NT; i++) d[i*DW +: DW] = DW'(i);
        return d;
    endfunction

    function automatic logic [NT*DW-1:0] fill(input logic [DW-1:0] v);
        logic [NT*DW-1:0] d;
        for (int i = 0; i < NT; i++) d[i*DW +: DW] = v;
        return d;
    endfunction

    function automatic int ref_sum(input logic [NT*DW-1:0] d, input logic [NT-1:0] w);
        int s;
        s = 0;
        for (int i = 0; i < NT; i++) begin
            if (w[i]) s += int'(d[i*DW +: DW]);
            else      s -= int'(d[i*DW +: DW]);
        end
        return s;
    endfunction

    // Present one window for one edge, check the registered result, then drop ivalid.
    task automatic apply(input string tag, input logic [NT*DW-1:0] d,
                         input logic [NT-1:0] w, input int exp);
        @(negedge clk);
        idata  = d;
        weight = w;
        ivalid = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_dout"}, dout, exp);
        chk({tag, "_ovalid"}, 32'(ovalid), 32'd1);
        @(negedge clk);
        ivalid = 1'b0;
    endtask

    initial begin
        logic [NT*DW-1:0] rd;
        logic [NT-1:0]    rw;
        logic [NT*DW-1:0] bb_d [3];
        logic [NT-1:0]    bb_w [3];
        int               bb_e [3];

        rstn   = 1'b0;
        ivalid = 1'b0;
        idata  = '0;
        weight = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 32'd0);
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        apply("ramp_pos", ramp(), 25'h1FFFFFF, 300);
        // ivalid low with different inputs: result held, ovalid cleared.
        idata  = fill(8'hFF);
        weight = '0;
        @(posedge clk);
        #1;
        chk("hold_dout", dout, 32'd300);
        chk("hold_ovalid", 32'(ovalid), 32'd0);

        apply("ramp_neg", ramp(), 25'h0000000, -300);
        apply("single_top", ramp(), 25'h1000000, -252);
        apply("max_pos", fill(8'hFF), 25'h1FFFFFF, 6375);
        apply("max_neg", fill(8'hFF), 25'h0000000, -6375);
        chk("max_neg_bits", dout, 32'hFFFFE719);
        apply("single_p0", fill(8'hFF), 25'h0000001, -5865);
        apply("ramp_odd", ramp(), 25'h0AAAAAA, -12);

        bb_d = '{ramp(), fill(8'hFF), ramp()};
        bb_w = '{25'h1FFFFFF, 25'h0000000, 25'h0AAAAAA};
        bb_e = '{300, -6375, -12};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idata  = bb_d[k];
            weight = bb_w[k];
            ivalid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_dout", k), dout, bb_e[k]);
            chk($sformatf("b2b%0d_ovalid", k), 32'(ovalid), 32'd1);
        end
        @(negedge clk);
        ivalid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_end_ovalid", 32'(ovalid), 32'd0);
        chk("b2b_end_dout", dout, -32'sd12);

        // Asynchronous reset between edges while a stream is active.
        @(negedge clk);
        idata  = ramp();
        weight = 25'h1FFFFFF;
        ivalid = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_dout", dout, 32'd300);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_dout", dout, 32'd0);
        chk("async_rst_ovalid", 32'(ovalid), 32'd0);
        @(posedge clk);
        #1;
        chk("in_rst_dout", dout, 32'd0);
        @(negedge clk);
        rstn   = 1'b1;
        ivalid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle_ovalid", 32'(ovalid), 32'd0);
        apply("post_rst_first", ramp(), 25'h1000000, -252);

        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < NT; i++) rd[i*DW +: DW] = DW'($urandom_range(0, 255));
            rw = NT'($urandom);
            apply($sformatf("rand%0d", n), rd, rw, ref_sum(rd, rw));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
